// File: rtl/writeback_grf_pkg.sv
// Shared pipeline definitions: datapath widths, the hardwired zero register
// and the architectural register indices used by the pipeline and hazard logic.
package writeback_grf_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int PC_W      = 32;
  localparam int CNT_W     = 32;
  localparam int REG_DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam logic [ADDR_W-1:0] REG_AT   = 5'd1;
  localparam logic [ADDR_W-1:0] REG_V0   = 5'd2;
  localparam logic [ADDR_W-1:0] REG_V1   = 5'd3;
  localparam logic [ADDR_W-1:0] REG_A0   = 5'd4;
  localparam logic [ADDR_W-1:0] REG_T0   = 5'd8;
  localparam logic [ADDR_W-1:0] REG_S0   = 5'd16;
  localparam logic [ADDR_W-1:0] REG_GP   = 5'd28;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_FP   = 5'd30;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/writeback_grf_trace.sv
// Commit trace record and running commit counter; kept apart from the array so
// the debug-only state can be stripped or retimed without touching the datapath.
module grf_trace #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit,
  input  logic [PC_W-1:0]   pc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              trace_valid,
  output logic [PC_W-1:0]   trace_pc,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output logic [CNT_W-1:0]  commit_count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_valid  <= 1'b0;
      trace_pc     <= '0;
      trace_addr   <= '0;
      trace_data   <= '0;
      commit_count <= '0;
    end else begin
      trace_valid <= commit;
      if (commit) begin
        trace_pc     <= pc;
        trace_addr   <= addr;
        trace_data   <= data;
        commit_count <= commit_count + CNT_W'(1);  // wraps silently
      end
    end
  end

endmodule

// File: rtl/writeback_grf.sv
// 32-entry general-purpose register file fed by the write-back stage, with two
// combinational decode read ports that bypass the in-flight write.
module writeback_grf #(
  parameter int DATA_W = writeback_grf_pkg::DATA_W,
  parameter int ADDR_W = writeback_grf_pkg::ADDR_W,
  parameter int CNT_W  = writeback_grf_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       W_PC,
  input  logic [ADDR_W-1:0] W_RegAddr,
  input  logic [DATA_W-1:0] W_RegData,
  input  logic              W_RegWrite,
  input  logic [ADDR_W-1:0] D_RsAddr,
  input  logic [ADDR_W-1:0] D_RtAddr,
  output logic [DATA_W-1:0] D_RsData,
  output logic [DATA_W-1:0] D_RtData,
  output logic              trace_valid,
  output logic [31:0]       trace_pc,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output logic [CNT_W-1:0]  commit_count
);

  import writeback_grf_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;

  // W_RegWrite gates first so an X address on a bubble cannot create a commit.
  assign commit = W_RegWrite && (W_RegAddr != ZERO_IDX);

  // NOTE: this array lives in flops and must read as zero straight out of
  // reset, so every entry is cleared; a RAM-mapped array could not be.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[W_RegAddr] <= W_RegData;
    end
  end

  assign D_RsData = (D_RsAddr == ZERO_IDX)              ? '0        :
                    (commit && D_RsAddr == W_RegAddr)   ? W_RegData :
                                                          regs[D_RsAddr];

  assign D_RtData = (D_RtAddr == ZERO_IDX)              ? '0        :
                    (commit && D_RtAddr == W_RegAddr)   ? W_RegData :
                                                          regs[D_RtAddr];

  grf_trace #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .PC_W   (32),
    .CNT_W  (CNT_W)
  ) u_trace (
    .clk          (clk),
    .reset        (reset),
    .commit       (commit),
    .pc           (W_PC),
    .addr         (W_RegAddr),
    .data         (W_RegData),
    .trace_valid  (trace_valid),
    .trace_pc     (trace_pc),
    .trace_addr   (trace_addr),
    .trace_data   (trace_data),
    .commit_count (commit_count)
  );

endmodule
